// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer
//   Walks a small per-layer configuration table and drives the CNN
//   accelerator one layer at a time: presents base address and layer
//   config, pulses layer start, waits for a fresh layer done, then
//   advances the weight/param base addresses for the next layer.
//
// Ports
//   HCLK, HRESET      clock, synchronous active-high reset
//   cfg_we/idx/data   layer table write {act_shift, bias_shift, is_conv3x3};
//                     dropped while busy
//   n_layers          layer count, sampled with seq_start
//   seq_start         start a run (IDLE only); seq_abort returns to IDLE
//   layer_done        accelerator done level (may be left high)
//   acc_base_addr     {param, weight} base address of the current layer
//   acc_layer_config  {16'b0, act, bias, idx, last, conv3x3, last, first}
//   acc_layer_start   one-cycle start pulse
//   busy, seq_done    run in progress / one-cycle end-of-run pulse
//   cur_layer, err    current layer index / sticky error flag
module cnn_layer_sequencer #(
  parameter int N_LAYER_MAX = 8,
  parameter int Ti          = 16,
  parameter int To          = 16,
  parameter int N           = 16,
  parameter int W_WADDR     = 20,
  parameter int W_PADDR     = 12,
  parameter int TIMEOUT     = 2**24
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic [8:0]  cfg_data,
  input  logic [3:0]  n_layers,
  input  logic        seq_start,
  input  logic        seq_abort,
  input  logic        layer_done,
  output logic [31:0] acc_base_addr,
  output logic [31:0] acc_layer_config,
  output logic        acc_layer_start,
  output logic        busy,
  output logic        seq_done,
  output logic [3:0]  cur_layer,
  output logic        err
);

  localparam int IDX_W = (N_LAYER_MAX > 1) ? $clog2(N_LAYER_MAX) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [W_WADDR-1:0] W_STEP_CONV = W_WADDR'(Ti * To * 9 / N);
  localparam logic [W_WADDR-1:0] W_STEP_1X1  = W_WADDR'(To);
  localparam logic [W_PADDR-1:0] P_STEP      = W_PADDR'(To);
  // The counter is compared against its value one cycle before it would
  // reach TIMEOUT-1, so the return to IDLE coincides with that count.
  localparam logic [WD_W-1:0]    WD_LAST     = WD_W'(TIMEOUT - 2);
  localparam logic [4:0]         N_MAX       = 5'(N_LAYER_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_WAIT_LOW, S_WAIT_DONE, S_ADVANCE, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [8:0]         layer_tbl [N_LAYER_MAX];
  logic [8:0]         entry;
  logic [3:0]         n_lat;
  logic [W_WADDR-1:0] weight_addr;
  logic [W_PADDR-1:0] param_addr;
  logic [WD_W-1:0]    wd_cnt;
  logic               start_ok;
  logic               is_last;
  logic               wd_expired;

  assign start_ok   = (n_layers != 4'd0) && ({1'b0, n_layers} <= N_MAX);
  assign is_last    = (cur_layer == n_lat - 4'd1);
  assign wd_expired = (wd_cnt == WD_LAST);
  assign entry      = layer_tbl[cur_layer[IDX_W-1:0]];

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    acc_layer_start = 1'b0;
    seq_done        = 1'b0;
    busy            = (state != S_IDLE);
    if (state != S_IDLE && seq_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (seq_start && start_ok) state_nxt = S_SETUP;
        S_SETUP:     state_nxt = S_PULSE;
        S_PULSE: begin
          acc_layer_start = 1'b1;
          state_nxt       = S_WAIT_LOW;
        end
        // A done level still high from the previous layer must drop first.
        S_WAIT_LOW:  if (wd_expired) state_nxt = S_IDLE;
                     else if (!layer_done) state_nxt = S_WAIT_DONE;
        S_WAIT_DONE: if (wd_expired) state_nxt = S_IDLE;
                     else if (layer_done) state_nxt = S_ADVANCE;
        S_ADVANCE:   state_nxt = is_last ? S_DONE : S_SETUP;
        S_DONE: begin
          seq_done  = 1'b1;
          state_nxt = S_IDLE;
        end
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < N_LAYER_MAX; i++) layer_tbl[i] <= '0;
      acc_base_addr    <= '0;
      acc_layer_config <= '0;
      cur_layer        <= '0;
      err              <= 1'b0;
      n_lat            <= '0;
      weight_addr      <= '0;
      param_addr       <= '0;
      wd_cnt           <= '0;
    end else begin
      if (state == S_IDLE && cfg_we) layer_tbl[cfg_idx] <= cfg_data;
      case (state)
        S_IDLE: begin
          if (seq_start) begin
            if (start_ok) begin
              n_lat       <= n_layers;
              err         <= 1'b0;
              cur_layer   <= '0;
              weight_addr <= '0;
              param_addr  <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          acc_base_addr    <= {param_addr, weight_addr};
          acc_layer_config <= {16'b0, entry[8:6], entry[5:1], cur_layer,
                               is_last, entry[0], is_last, (cur_layer == 4'd0)};
        end
        S_PULSE: wd_cnt <= '0;
        S_WAIT_LOW, S_WAIT_DONE: begin
          if (!seq_abort && wd_expired) err <= 1'b1;
          wd_cnt <= wd_cnt + 1'b1;
        end
        // Conv kind comes from the config latched in SETUP for this layer.
        S_ADVANCE: begin
          if (!seq_abort) begin
            weight_addr <= weight_addr + (acc_layer_config[2] ? W_STEP_CONV : W_STEP_1X1);
            param_addr  <= param_addr + P_STEP;
            if (!is_last) cur_layer <= cur_layer + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer (TIMEOUT overridden to 100).
// A layer-level model turns the shadow table into the expected list of
// {config, base address, index} per start pulse; a compare process checks
// every start pulse and every seq_done against it, and directed tests pin
// latencies and literal values.
module tb_cnn_layer_sequencer;
  localparam int TMO = 100;

  logic        HCLK = 1'b0;
  logic        HRESET, cfg_we, seq_start, seq_abort, layer_done;
  logic [2:0]  cfg_idx;
  logic [8:0]  cfg_data;
  logic [3:0]  n_layers;
  logic [31:0] acc_base_addr, acc_layer_config;
  logic        acc_layer_start, busy, seq_done, err;
  logic [3:0]  cur_layer;
  logic        done_auto, done_man;

  assign layer_done = done_auto | done_man;

  cnn_layer_sequencer #(.TIMEOUT(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .n_layers(n_layers), .seq_start(seq_start),
    .seq_abort(seq_abort), .layer_done(layer_done),
    .acc_base_addr(acc_base_addr), .acc_layer_config(acc_layer_config),
    .acc_layer_start(acc_layer_start), .busy(busy), .seq_done(seq_done),
    .cur_layer(cur_layer), .err(err)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // ---------------- layer-level model ----------------
  logic [8:0]  model_tbl [8];
  logic [31:0] exp_cfg[$], exp_base[$];
  int          exp_idx[$];

  function automatic void build_model(input int n);
    logic [31:0] w, p;
    int act, bias, conv, first, last;
    exp_cfg.delete(); exp_base.delete(); exp_idx.delete();
    w = 0; p = 0;
    for (int i = 0; i < n; i++) begin
      act   = int'(model_tbl[i][8:6]);
      bias  = int'(model_tbl[i][5:1]);
      conv  = int'(model_tbl[i][0]);
      first = (i == 0) ? 1 : 0;
      last  = (i == n - 1) ? 1 : 0;
      // is_last occupies bits 3 and 1 -> weight 8 + 2
      exp_cfg.push_back(32'(act * 8192 + bias * 256 + i * 16 + last * 10 + conv * 4 + first));
      exp_base.push_back(((p % 4096) << 20) | (w % 1048576));
      exp_idx.push_back(i);
      w = w + 32'((conv != 0) ? 144 : 16);
      p = p + 32'd16;
    end
  endfunction

  // ---------------- observation / compare ----------------
  int          start_cyc[$];
  logic [31:0] got_cfg[$], got_base[$];
  int          n_done_pulses = 0;
  int          done_cyc = 0;

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET !== 1'b1) begin
        if (acc_layer_start === 1'b1) begin
          start_cyc.push_back(cyc);
          got_cfg.push_back(acc_layer_config);
          got_base.push_back(acc_base_addr);
          check("start_expected", (exp_cfg.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_cfg.size() > 0) begin
            check("layer_cfg", acc_layer_config, exp_cfg.pop_front());
            check("layer_base", acc_base_addr, exp_base.pop_front());
            check("cur_layer", 32'(cur_layer), 32'(exp_idx.pop_front()));
            check("busy_at_start", 32'(busy), 32'd1);
          end
        end
        if (seq_done === 1'b1) begin
          n_done_pulses++;
          done_cyc = cyc;
          check("done_after_all_layers", 32'(exp_cfg.size()), 32'd0);
        end
      end
    end
  end

  // Done responder: one-cycle done 50 cycles after each start pulse.
  bit auto_en = 0;
  int cd = 0;
  initial begin
    done_auto = 1'b0;
    forever begin
      @(posedge HCLK); #1;
      done_auto = 1'b0;
      if (!auto_en) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) done_auto = 1'b1;
        end
        if (acc_layer_start === 1'b1) cd = 50;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  task automatic wr_cfg(input int idx, input logic [8:0] d);
    bit taken;
    taken = (busy == 1'b0);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (taken) model_tbl[idx] = d;
  endtask

  task automatic start_seq(input int n);
    if (n >= 1 && n <= 8 && busy == 1'b0) build_model(n);
    n_layers = 4'(n); seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic clear_obs();
    start_cyc.delete(); got_cfg.delete(); got_base.delete();
    exp_cfg.delete(); exp_base.delete(); exp_idx.delete();
    n_done_pulses = 0;
  endtask

  task automatic wait_starts(input string nm, input int n, input int lim);
    int k = 0;
    while (start_cyc.size() < n && k < lim) begin @(negedge HCLK); #1; k++; end
    check(nm, 32'(start_cyc.size()), 32'(n));
  endtask

  task automatic wait_dones(input string nm, input int n, input int lim);
    int k = 0;
    while (n_done_pulses < n && k < lim) begin @(negedge HCLK); #1; k++; end
    check(nm, 32'(n_done_pulses), 32'(n));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_base"},  acc_base_addr, 32'd0);
    check({pfx, "_cfg"},   acc_layer_config, 32'd0);
    check({pfx, "_start"}, 32'(acc_layer_start), 32'd0);
    check({pfx, "_busy"},  32'(busy), 32'd0);
    check({pfx, "_done"},  32'(seq_done), 32'd0);
    check({pfx, "_cur"},   32'(cur_layer), 32'd0);
    check({pfx, "_err"},   32'(err), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c, idle_cyc, k;
    HRESET = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; n_layers = '0;
    seq_start = 1'b0; seq_abort = 1'b0; done_man = 1'b0;
    for (int i = 0; i < 8; i++) model_tbl[i] = '0;
    tick(2);
    @(negedge HCLK);
    check_reset_outputs("reset");
    tick();
    HRESET = 1'b0;
    tick();

    // Three-layer network
    wr_cfg(0, {3'd7, 5'd9, 1'b0});
    wr_cfg(1, {3'd7, 5'd17, 1'b1});
    wr_cfg(2, {3'd7, 5'd17, 1'b1});
    clear_obs(); auto_en = 1;
    start_seq(3);
    @(negedge HCLK);
    check("t1_setup_busy", 32'(busy), 32'd1);
    check("t1_setup_nostart", 32'(acc_layer_start), 32'd0);
    @(negedge HCLK);
    check("t1_pulse_k2", 32'(acc_layer_start), 32'd1);
    @(negedge HCLK);
    check("t1_pulse_one_cycle", 32'(acc_layer_start), 32'd0);
    wait_dones("t1_seq_done", 1, 400);
    @(negedge HCLK); #1;
    check("t1_idle_after_done", 32'(busy), 32'd0);
    tick(10);
    check("t1_starts", 32'(start_cyc.size()), 32'd3);
    check("t1_dones", 32'(n_done_pulses), 32'd1);
    if (start_cyc.size() == 3) begin
      check("t1_cfg0", got_cfg[0], 32'h0000E901);
      check("t1_cfg1", got_cfg[1], 32'h0000F114);
      check("t1_cfg2", got_cfg[2], 32'h0000F12E);
      check("t1_base0", got_base[0], 32'h00000000);
      check("t1_base1", got_base[1], 32'h01000010);
      check("t1_base2", got_base[2], 32'h020000A0);
      check("t1_spacing01", 32'(start_cyc[1] - start_cyc[0]), 32'd53);
      check("t1_spacing12", 32'(start_cyc[2] - start_cyc[1]), 32'd53);
      check("t1_done_lat", 32'(done_cyc - start_cyc[2]), 32'd52);
    end

    // Sticky done
    auto_en = 0; clear_obs();
    start_seq(2);
    wait_starts("t2_start0", 1, 10);
    tick(10);
    done_man = 1'b1; c = cyc;
    wait_starts("t2_start1", 2, 10);
    if (start_cyc.size() == 2) check("t2_start1_lat", 32'(start_cyc[1] - c), 32'd3);
    tick(20);
    done_man = 1'b0;
    tick(10);
    check("t2_no_early_start", 32'(start_cyc.size()), 32'd2);
    check("t2_still_busy", 32'(busy), 32'd1);
    check("t2_no_done", 32'(n_done_pulses), 32'd0);
    check("t2_cur_layer", 32'(cur_layer), 32'd1);
    done_man = 1'b1; c = cyc;
    tick();
    done_man = 1'b0;
    wait_dones("t2_seq_done", 1, 10);
    check("t2_done_lat", 32'(done_cyc - c), 32'd2);
    tick(3);

    // Illegal length
    clear_obs();
    start_seq(0);
    @(negedge HCLK);
    check("t3_n0_err", 32'(err), 32'd1);
    check("t3_n0_busy", 32'(busy), 32'd0);
    tick(5);
    check("t3_n0_nostart", 32'(start_cyc.size()), 32'd0);
    auto_en = 1;
    start_seq(1);
    @(negedge HCLK);
    check("t3_err_cleared", 32'(err), 32'd0);
    wait_dones("t3_valid_run", 1, 100);
    tick(2);
    clear_obs();
    start_seq(9);
    @(negedge HCLK);
    check("t3_n9_err", 32'(err), 32'd1);
    check("t3_n9_busy", 32'(busy), 32'd0);
    tick(5);
    check("t3_n9_nostart", 32'(start_cyc.size()), 32'd0);

    // Abort in WAIT_DONE of layer 1
    clear_obs();
    start_seq(3);
    wait_starts("t4_start1", 2, 100);
    tick(5);
    auto_en = 0; seq_abort = 1'b1;
    tick();
    seq_abort = 1'b0;
    @(negedge HCLK);
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_err", 32'(err), 32'd0);
    tick(60);
    check("t4_no_done", 32'(n_done_pulses), 32'd0);
    check("t4_no_more_starts", 32'(start_cyc.size()), 32'd2);
    clear_obs(); auto_en = 1;
    start_seq(3);
    wait_starts("t4_restart", 1, 10);
    if (start_cyc.size() >= 1) begin
      check("t4_restart_base", got_base[0], 32'h00000000);
      check("t4_restart_cfg", got_cfg[0], 32'h0000E901);
    end
    wait_dones("t4_restart_done", 1, 400);
    tick(2);

    // Watchdog timeout
    auto_en = 0; clear_obs();
    start_seq(1);
    wait_starts("t5_start", 1, 10);
    k = 0;
    while (busy === 1'b1 && k < 200) begin @(negedge HCLK); #1; k++; end
    idle_cyc = cyc;
    if (start_cyc.size() == 1) check("t5_timeout_lat", 32'(idle_cyc - start_cyc[0]), 32'd100);
    check("t5_err", 32'(err), 32'd1);
    check("t5_no_done", 32'(n_done_pulses), 32'd0);
    tick(2);

    // Table write while busy is dropped
    clear_obs(); auto_en = 1;
    start_seq(3);
    tick(3);
    wr_cfg(0, 9'h1FF);
    wait_dones("t6_run", 1, 400);
    tick(2);
    clear_obs();
    start_seq(1);
    wait_starts("t6_readback", 1, 10);
    if (start_cyc.size() == 1) check("t6_table_kept", got_cfg[0], 32'h0000E90B);
    wait_dones("t6_readback_done", 1, 100);
    tick(2);

    // Reset mid-layer 2
    clear_obs();
    start_seq(3);
    wait_starts("t6_layer2", 3, 400);
    tick(5);
    auto_en = 0; HRESET = 1'b1;
    clear_obs();
    for (int i = 0; i < 8; i++) model_tbl[i] = '0;
    tick();
    @(negedge HCLK);
    check_reset_outputs("t6_rst");
    tick();
    HRESET = 1'b0;
    tick(5);
    check("t6_rst_nostart", 32'(start_cyc.size()), 32'd0);
    check("t6_rst_nodone", 32'(n_done_pulses), 32'd0);
    auto_en = 1;
    start_seq(1);
    wait_starts("t6_post_rst", 1, 10);
    if (start_cyc.size() == 1) begin
      check("t6_table_cleared", got_cfg[0], 32'h0000000B);
      check("t6_post_rst_base", got_base[0], 32'h00000000);
    end
    wait_dones("t6_post_rst_done", 1, 100);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
